// File: rtl/axi_arb_sched_pkg.sv
// axi_arb_pkg: shared state encoding, default parameters and width helper for the scheduler.
package axi_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int DEF_DATA_WIDTH = 7;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_MAX_BURST  = 4;

    function automatic int src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_arb_sched_if.sv
// axi_arb_sched_if: requester channels in, one registered valid/ready stage out.
interface axi_arb_sched_if #(
    parameter int DATA_WIDTH = axi_arb_pkg::DEF_DATA_WIDTH,
    parameter int NUM_REQ    = axi_arb_pkg::DEF_NUM_REQ
);
    import axi_arb_pkg::*;

    localparam int SRC_W = src_w(NUM_REQ);

    logic [NUM_REQ*DATA_WIDTH-1:0] up_bus;
    logic [NUM_REQ-1:0]            up_val;
    logic [NUM_REQ-1:0]            up_rdy;
    logic [DATA_WIDTH-1:0]         dn_bus;
    logic                          dn_val;
    logic                          dn_rdy;
    logic [SRC_W-1:0]              dn_src;
    logic                          busy;

    modport slave (
        input  up_bus, up_val, dn_rdy,
        output up_rdy, dn_bus, dn_val, dn_src, busy
    );

    modport master (
        output up_bus, up_val, dn_rdy,
        input  up_rdy, dn_bus, dn_val, dn_src, busy
    );

endinterface

// File: rtl/axi_arb_sched_rr_pick.sv
// axi_rr_pick: first asserted request at or after ptr_i, wrapping modulo NUM_REQ.
module axi_rr_pick
    import axi_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int W       = src_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [W-1:0]       ptr_i,
    output logic               found_o,
    output logic [W-1:0]       idx_o
);

    logic [W-1:0] j;

    // Scan farthest offset first so the closest hit to ptr_i is the one left standing.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        j       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = W'((int'(ptr_i) + k) % NUM_REQ);
            if (req_i[j]) begin
                found_o = 1'b1;
                idx_o   = j;
            end
        end
    end

endmodule

// File: rtl/axi_arb_sched.sv
// axi_arb_sched: round-robin burst scheduler feeding one registered valid/ready stage,
// tagging each beat with the requester that produced it.
module axi_arb_sched
    import axi_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    axi_arb_sched_if.slave bus
);

    localparam int SRC_W = src_w(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_e                state_q;
    logic [SRC_W-1:0]      ptr_q;
    logic [SRC_W-1:0]      ptr_d;
    logic [SRC_W-1:0]      owner_q;
    logic [SRC_W-1:0]      pick_idx;
    logic [CNT_W-1:0]      cnt_q;
    logic                  dn_val_q;
    logic [DATA_WIDTH-1:0] dn_bus_q;
    logic [SRC_W-1:0]      dn_src_q;
    logic                  found;
    logic                  grant;
    logic                  own_rdy;
    logic                  own_val;
    logic                  xfer;
    logic                  done;
    logic [DATA_WIDTH-1:0] pay [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_pay
        assign pay[g] = bus.up_bus[g*DATA_WIDTH +: DATA_WIDTH];
    end

    axi_rr_pick #(.NUM_REQ(NUM_REQ), .W(SRC_W)) u_pick (
        .req_i   (bus.up_val),
        .ptr_i   (ptr_q),
        .found_o (found),
        .idx_o   (pick_idx)
    );

    assign grant   = state_q == GRANT;
    assign own_rdy = grant && (!dn_val_q || bus.dn_rdy);
    assign own_val = bus.up_val[owner_q];
    assign xfer    = own_rdy && own_val;
    // The owner losing valid ends the grant even in a stalled cycle; a beat already registered still drains.
    assign done    = grant && (!own_val || (xfer && cnt_q == CNT_W'(MAX_BURST - 1)));
    assign ptr_d   = (owner_q == SRC_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    assign bus.up_rdy = own_rdy ? NUM_REQ'(1) << owner_q : '0;
    assign bus.dn_bus = dn_bus_q;
    assign bus.dn_val = dn_val_q;
    assign bus.dn_src = dn_src_q;
    assign bus.busy   = grant;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            dn_val_q <= 1'b0;
            dn_bus_q <= '0;
            dn_src_q <= '0;
        end else begin
            if (xfer) begin
                dn_bus_q <= pay[owner_q];
                dn_src_q <= owner_q;
                cnt_q    <= cnt_q + 1'b1;
            end
            dn_val_q <= xfer || (dn_val_q && !bus.dn_rdy);
            if (!grant && found) begin
                state_q <= GRANT;
                owner_q <= pick_idx;
                cnt_q   <= '0;
            end else if (done) begin
                state_q <= IDLE;
                ptr_q   <= ptr_d;
            end
        end
    end

endmodule

// File: tb/tb_axi_arb_sched.sv
// tb_axi_arb_sched: directed scenarios plus randomized traffic, checked every cycle
// against a grant/beat-count reference model and an in-order beat scoreboard.
module tb_axi_arb_sched;

    localparam int DW = 7;
    localparam int NR = 4;
    localparam int MB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    axi_arb_sched_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    axi_arb_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_run  = 0;
    int n_fail = 0;

    logic [DW-1:0] pay [NR];
    logic [NR-1:0] val  = '0;
    logic [NR-1:0] acc  = '0;
    int            left [NR];
    int            nxt  [NR];
    logic          drdy = 1'b1;
    bit            rnd  = 1'b0;

    int            m_own   = -1;
    int            m_ptr   = 0;
    int            m_beats = 0;
    logic          m_dval  = 1'b0;
    logic [DW-1:0] m_dbus  = '0;
    int            m_dsrc  = 0;
    logic [8:0]    sb [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] gen(input int i);
        gen = rnd ? DW'($urandom) : DW'(nxt[i]);
        nxt[i]++;
    endfunction

    // Requesters hold a beat until accepted, then present the next one while their budget lasts.
    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
                left[i]--;
                if (left[i] == 0) val[i] = 1'b0;
                else pay[i] = gen(i);
            end
            if (!val[i] && rnd && left[i] == 0 && $urandom_range(2) == 0) left[i] = $urandom_range(6, 1);
            if (!val[i] && left[i] > 0) begin
                val[i] = 1'b1;
                pay[i] = gen(i);
            end
        end
        if (rnd) drdy = $urandom_range(3) != 0;
        bus.up_val = val;
        bus.dn_rdy = drdy;
        for (int i = 0; i < NR; i++) bus.up_bus[i*DW +: DW] = pay[i];
    endtask

    task automatic step();
        logic [NR-1:0] exp_rdy;
        logic          found;
        @(negedge clk);
        drive();
        #2;
        exp_rdy = '0;
        if (m_own >= 0 && (!m_dval || drdy)) exp_rdy[m_own] = 1'b1;
        check("up_rdy", bus.up_rdy, exp_rdy);
        check("busy", bus.busy, m_own >= 0);
        check("dn_val", bus.dn_val, m_dval);
        check("dn_bus", bus.dn_bus, m_dbus);
        check("dn_src", bus.dn_src, m_dsrc);
        if (m_dval && drdy && sb.size() > 0) check("deliver", {bus.dn_src, bus.dn_bus}, sb.pop_front());
        acc = val & exp_rdy;
        if (|acc) begin
            sb.push_back({2'(m_own), pay[m_own]});
            m_dval = 1'b1;
            m_dbus = pay[m_own];
            m_dsrc = m_own;
        end else if (drdy) begin
            m_dval = 1'b0;
        end
        if (m_own < 0) begin
            found = 1'b0;
            for (int k = 0; k < NR; k++) begin
                if (!found && val[(m_ptr + k) % NR]) begin
                    found   = 1'b1;
                    m_own   = (m_ptr + k) % NR;
                    m_beats = 0;
                end
            end
        end else begin
            m_beats += int'(|acc);
            if (m_beats == MB || !val[m_own]) begin
                m_ptr = (m_own + 1) % NR;
                m_own = -1;
            end
        end
        @(posedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Asserted between edges so the clearing is seen to be asynchronous.
    task automatic async_reset();
        #1 rst_n = 1'b0;
        #1;
        check("rst_dn_val", bus.dn_val, 1'b0);
        check("rst_up_rdy", bus.up_rdy, '0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_dn_src", bus.dn_src, '0);
        check("rst_dn_bus", bus.dn_bus, '0);
        m_own   = -1;
        m_ptr   = 0;
        m_beats = 0;
        m_dval  = 1'b0;
        m_dbus  = '0;
        m_dsrc  = 0;
        acc     = '0;
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            pay[i]  = '0;
            left[i] = 0;
            nxt[i]  = 0;
        end
        bus.up_val = '0;
        bus.up_bus = '0;
        bus.dn_rdy = 1'b1;
        async_reset();
        run(10);
        left[1] = 9;
        nxt[1]  = 'h11;
        run(16);
        async_reset();
        left = '{8, 4, 4, 4};
        nxt  = '{'h40, 'h50, 'h60, 'h70};
        run(30);
        async_reset();
        left[2] = 4;
        nxt[2]  = 'h2a;
        run(2);
        drdy = 1'b0;
        run(5);
        #1;
        check("bp_hold_bus", bus.dn_bus, 7'h2a);
        check("bp_hold_val", bus.dn_val, 1'b1);
        check("bp_hold_rdy", bus.up_rdy, '0);
        drdy = 1'b1;
        run(10);
        left[3] = 2;
        left[0] = 3;
        run(12);
        left[2] = 6;
        left[0] = 6;
        run(3);
        async_reset();
        run(20);
        rnd = 1'b1;
        run(3000);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
